// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - core/DMA arbiter for one single-port RAM with one-cycle read return
// Optional DMA starvation guard (PRI/WIN FSM) is built when MEM_ARB_STARVE_GUARD_EN is defined.
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int STARVE_MAX = 4,
    parameter int DMA_WIN    = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,

    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic              core_half_i,
    input  logic [ADDR_W:0]   core_addr_i,
    input  logic [31:0]       core_wdata_i,
    output logic              core_stall_o,
    output logic              core_rvalid_o,
    output logic [31:0]       core_rdata_o,

    input  logic              dma_req_i,
    input  logic              dma_we_i,
    input  logic [ADDR_W-1:0] dma_addr_i,
    input  logic [31:0]       dma_wdata_i,
    output logic              dma_gnt_o,
    output logic              dma_rvalid_o,
    output logic [31:0]       dma_rdata_o,

    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    logic core_gnt;
    logic dma_gnt;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int SW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
    localparam int WW = $clog2(DMA_WIN + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX - 1);
    localparam logic [WW-1:0] WIN_LOAD   = WW'(DMA_WIN);
    localparam logic [WW-1:0] WIN_LAST   = WW'(1);

    typedef enum logic {
        ST_PRI = 1'b0,
        ST_WIN = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [WW-1:0] win_q, win_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_PRI;
            starve_q <= '0;
            win_q    <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            win_q    <= win_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        win_d    = win_q;
        case (state_q)
            ST_PRI: begin
                if (!dma_req_i || dma_gnt) begin
                    starve_d = '0;
                end else if (starve_q == STARVE_TOP) begin
                    state_d  = ST_WIN;
                    starve_d = '0;
                    win_d    = WIN_LOAD;
                end else begin
                    starve_d = starve_q + 1'b1;
                end
            end
            ST_WIN: begin
                // A DMA master that lets go of the bus forfeits the rest of its window.
                if (!dma_req_i) begin
                    state_d = ST_PRI;
                    win_d   = '0;
                end else begin
                    win_d = win_q - 1'b1;
                    if (win_q == WIN_LAST) begin
                        state_d = ST_PRI;
                    end
                end
            end
            default: begin
                state_d = ST_PRI;
            end
        endcase
    end

    always_comb begin
        core_gnt = 1'b0;
        dma_gnt  = 1'b0;
        if (state_q == ST_WIN && dma_req_i) begin
            dma_gnt = 1'b1;
        end else if (core_req_i) begin
            core_gnt = 1'b1;
        end else if (dma_req_i) begin
            dma_gnt = 1'b1;
        end
    end
`else
    always_comb begin
        core_gnt = core_req_i;
        dma_gnt  = dma_req_i & ~core_req_i;
    end
`endif

    assign core_stall_o = core_req_i & ~core_gnt;
    assign dma_gnt_o    = dma_gnt;

    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'b0000;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (core_gnt) begin
            mem_en_o   = 1'b1;
            mem_we_o   = core_we_i;
            mem_addr_o = core_addr_i[ADDR_W:1];
            if (core_half_i) begin
                mem_be_o    = core_addr_i[0] ? 4'b1100 : 4'b0011;
                mem_wdata_o = {core_wdata_i[15:0], core_wdata_i[15:0]};
            end else begin
                mem_be_o    = 4'b1111;
                mem_wdata_o = core_wdata_i;
            end
        end else if (dma_gnt) begin
            mem_en_o    = 1'b1;
            mem_we_o    = dma_we_i;
            mem_be_o    = 4'b1111;
            mem_addr_o  = dma_addr_i;
            mem_wdata_o = dma_wdata_i;
        end
    end

    // Read tag: who issued last cycle's read, and which halfword lane the core wanted.
    logic        rd_core_q;
    logic        rd_dma_q;
    logic        rd_half_q;
    logic        rd_lane_q;
    logic [31:0] core_rdata_q;
    logic [31:0] dma_rdata_q;
    logic [31:0] core_rdata_sel;

    always_comb begin
        core_rdata_sel = mem_rdata_i;
        if (rd_half_q) begin
            core_rdata_sel = {16'h0000, rd_lane_q ? mem_rdata_i[31:16] : mem_rdata_i[15:0]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_core_q    <= 1'b0;
            rd_dma_q     <= 1'b0;
            rd_half_q    <= 1'b0;
            rd_lane_q    <= 1'b0;
            core_rdata_q <= '0;
            dma_rdata_q  <= '0;
        end else begin
            rd_core_q <= core_gnt & ~core_we_i;
            rd_dma_q  <= dma_gnt & ~dma_we_i;
            if (core_gnt) begin
                rd_half_q <= core_half_i;
                rd_lane_q <= core_addr_i[0];
            end
            if (rd_core_q) begin
                core_rdata_q <= core_rdata_sel;
            end
            if (rd_dma_q) begin
                dma_rdata_q <= mem_rdata_i;
            end
        end
    end

    assign core_rvalid_o = rd_core_q;
    assign dma_rvalid_o  = rd_dma_q;
    assign core_rdata_o  = rd_core_q ? core_rdata_sel : core_rdata_q;
    assign dma_rdata_o   = rd_dma_q ? mem_rdata_i : dma_rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, word address width.
REQ-002 Parameter STARVE_MAX, default 4, consecutive denied DMA cycles before a forced DMA window.
REQ-003 Parameter DMA_WIN, default 2, beats in a forced DMA window.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 core_req  in  1  core load/store request; core_we  in  1  store; core_half  in  1  halfword access.
REQ-007 core_addr  in  ADDR_W+1  halfword-granular address; bit 0 selects halfword lane.
REQ-008 core_wdata  in  32  store data; halfword stores use bits 15:0.
REQ-009 core_stall  out  1  core_req high and not granted this cycle.
REQ-010 core_rvalid  out  1  core read data valid; core_rdata  out  32  read data.
REQ-011 dma_req  in  1; dma_we  in  1; dma_addr  in  ADDR_W; dma_wdata  in  32  image-loader word access.
REQ-012 dma_gnt  out  1  DMA access accepted this cycle; dma_rvalid  out  1; dma_rdata  out  32.
REQ-013 mem_en  out  1; mem_we  out  1; mem_be  out  4; mem_addr  out  ADDR_W; mem_wdata  out  32  single-port RAM.
REQ-014 mem_rdata  in  32  RAM read data, valid one cycle after a read issue.

Function
REQ-015 At most one access SHALL be issued to the RAM per cycle; mem_* driven combinationally from the granted requester; mem_en = 0 when none granted.
REQ-016 FSM states PRI and WIN; PRI: core wins when core_req = 1, else DMA wins when dma_req = 1.
REQ-017 WIN: DMA wins when dma_req = 1; core stalled; each granted DMA beat decrements the window counter.
REQ-018 PRI -> WIN when starve counter = STARVE_MAX-1 and DMA is denied this cycle; window counter loads DMA_WIN.
REQ-019 WIN -> PRI after the DMA_WIN-th beat, or immediately in any cycle where dma_req = 0 (window abandoned).
REQ-020 Starve counter: +1 per PRI cycle with dma_req = 1 and DMA denied; cleared on DMA grant, on dma_req = 0, and on entry to WIN; saturates at STARVE_MAX-1.
REQ-021 Core word access: mem_addr = core_addr[ADDR_W:1], mem_be = 1111; core_half = 0 with core_addr[0] = 1 is illegal, behaviour unspecified.
REQ-022 Core halfword store: mem_wdata = {core_wdata[15:0], core_wdata[15:0]}; mem_be = 0011 for lane 0, 1100 for lane 1.
REQ-023 DMA accesses are always word: mem_be = 1111.
REQ-024 Read latency SHALL be one cycle: a registered owner/lane tag routes mem_rdata to the issuing requester; only that requester's rvalid pulses for one cycle.
REQ-025 Core halfword read: core_rdata = zero-extended selected lane (lane 1 = bits 31:16).
REQ-026 rdata of a non-owner SHALL hold its last value; writes produce no rvalid.

Reset
REQ-027 On rst_n low, immediately: state PRI, starve and window counters 0, read tag cleared, core_rvalid = dma_rvalid = 0, core_rdata = dma_rdata = 0.
REQ-028 Reset mid-window or mid-read SHALL drop the window and any pending rvalid; first post-reset cycle arbitrates as PRI.

Configuration
REQ-029 Macro MEM_ARB_STARVE_GUARD_EN defined: REQ-017..020 apply.
REQ-030 Macro undefined: WIN and both counters absent; strict core priority; DMA granted only when core_req = 0.

Verification
REQ-031 Core read word 0x0004 at cycle 0, mem_rdata = 0xDEADBEEF at cycle 1 -> core_rvalid = 1, core_rdata = 0xDEADBEEF at cycle 1; dma_rvalid = 0.
REQ-032 Core halfword store addr 0x0003, wdata 0x0000ABCD -> mem_addr = 0x0001, mem_be = 1100, mem_wdata = 0xABCDABCD.
REQ-033 Guard enabled, core_req and dma_req held high, STARVE_MAX = 4, DMA_WIN = 2 -> core granted cycles 0-3, dma_gnt cycles 4-5, core stalled 4-5, core granted cycle 6.
REQ-034 Guard enabled, in WIN, dma_req drops after 1 beat -> next cycle PRI, core granted, starve counter 0.
REQ-035 DMA read issued, rst_n pulsed low before next edge -> dma_rvalid stays 0, state PRI.
REQ-036 Guard disabled, both requests held 10 cycles -> dma_gnt never asserted; core granted all 10 cycles.
